nested_in_service_ctrl: RTL
===========================

NESTED_IN_SERVICE_CTRL -- requirements
Module: nested_in_service_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning channel count; legal values 2, 4, 8, 16, 32.
REQ-002 SHALL have derived localparam W = log2(N), meaning level-number width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port ack_valid  in  1  interrupt acknowledge strobe, one cycle per acknowledge.
REQ-006 SHALL have port ack_vector  in  N  one-hot level being acknowledged.
REQ-007 SHALL have port aeoi  in  1  auto-EOI mode enable.
REQ-008 SHALL have port smm  in  1  special mask mode enable.
REQ-009 SHALL have port mask  in  N  interrupt mask register image.
REQ-010 SHALL have port cmd_valid  in  1  EOI/priority command strobe.
REQ-011 SHALL have port cmd_op  in  3  command opcode.
REQ-012 SHALL have port cmd_level  in  W  level operand for specific commands.
REQ-013 SHALL have port isr  out  N  in-service register.
REQ-014 SHALL have port highest_in_service  out  N  one-hot highest-priority in-service level, or zero.
REQ-015 SHALL have port highest_id  out  W  binary index of highest_in_service; 0 when none.
REQ-016 SHALL have port depth  out  W+1  count of set isr bits (nesting depth).
REQ-017 SHALL have port lowest_level  out  W  current lowest-priority level L.
REQ-018 SHALL have port ack_error  out  1  sticky acknowledge protocol error.

Function
REQ-019 Priority SHALL be circular: level (L+1) mod N highest, then ascending with wrap, L lowest.
REQ-020 cmd_op decode SHALL be: 000 nop; 001 non-specific EOI; 010 specific EOI; 011 rotate on non-specific EOI; 100 rotate on specific EOI; 101 set priority; 110 set rotate-in-AEOI flag; 111 clear rotate-in-AEOI flag.
REQ-021 Effective set E SHALL be isr & ~mask when smm=1, else isr.
REQ-022 Non-specific EOI (001) SHALL clear the highest-priority bit of E; no effect when E is zero.
REQ-023 Specific EOI (010) SHALL clear isr[cmd_level] regardless of smm/mask.
REQ-024 Op 011 SHALL act as 001 and set L to the cleared level; L unchanged when nothing cleared.
REQ-025 Op 100 SHALL act as 010 and set L = cmd_level unconditionally.
REQ-026 Op 101 SHALL set L = cmd_level without touching isr.
REQ-027 Ops 110/111 SHALL set/clear internal flag rot_aeoi.
REQ-028 Acknowledge with aeoi=0 SHALL set isr bit given by ack_vector.
REQ-029 Acknowledge with aeoi=1 SHALL leave isr unchanged; if rot_aeoi=1, L SHALL become the acknowledged level.
REQ-030 Same-cycle command and acknowledge: command SHALL apply to current isr first, then acknowledge bit set; acknowledge AEOI rotation SHALL override command L update.
REQ-031 ack_error SHALL set when ack_valid=1 and ack_vector is not exactly one-hot or its bit is already set in isr; erroneous acknowledge SHALL NOT modify isr or L; only reset clears ack_error.
REQ-032 highest_in_service, highest_id, depth SHALL be registered, computed from next-state isr, next-state L and current smm/mask, so all outputs are consistent in the cycle after the edge.
REQ-033 Latency: command or acknowledge sampled at edge k SHALL be visible on all outputs after edge k; no other pipeline delay.
REQ-034 Back-to-back commands every cycle SHALL be accepted; no stall or ready.
REQ-035 cmd_level and acknowledge index SHALL be interpreted mod N (no out-of-range values exist).

Reset
REQ-036 reset=0 at a rising edge SHALL force isr=0, highest_in_service=0, highest_id=0, depth=0, L=N-1, rot_aeoi=0, ack_error=0, overriding any same-cycle command or acknowledge.
REQ-037 Reset mid-nesting SHALL discard all in-service state; first post-reset edge with reset=1 behaves as fresh.

Verification
REQ-038 N=8: ack levels 3, 5, 1 (aeoi=0) -> isr=0x2A, highest_id=1, depth=3; op 001 -> isr=0x28, highest_id=3.
REQ-039 N=8: op 101 level 4 then ack 2 and 6 -> highest_id=6 (priority 5,6,7,0..4); op 011 -> isr=0x04, L=6.
REQ-040 N=8: isr=0x0A, smm=1, mask=0x02, op 001 -> isr=0x02, highest_in_service=0 thereafter.
REQ-041 N=8: op 110, aeoi=1, ack level 7 -> isr unchanged 0x00, L=7; ack_vector=0x06 -> ack_error=1, isr unchanged.
REQ-042 N=8: same cycle op 010 level 2 with ack level 2, isr=0x04 -> isr=0x04 (clear then set), depth=1.
REQ-043 N=16: isr nonzero, reset=0 one cycle concurrent with ack -> all outputs zero, lowest_level=15.

Source files
------------

// File: rtl/nested_in_service_ctrl.sv
// nested_in_service_ctrl
//   In-service tracker for a nested, circular-priority interrupt controller.
//   It records acknowledged levels in the in-service register, retires them
//   through EOI commands, rotates the lowest-priority level L, and publishes
//   the highest-priority in-service level.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   ack_valid           acknowledge strobe, one cycle per acknowledge
//   ack_vector[N]       one-hot level being acknowledged
//   aeoi                auto-EOI mode: an acknowledge does not set isr
//   smm                 special mask mode: masked isr bits hidden from priority
//   mask[N]             interrupt mask register image
//   cmd_valid           EOI / priority command strobe
//   cmd_op[3]           command opcode
//   cmd_level[W]        level operand for specific commands
//   isr[N]              in-service register
//   highest_in_service  one-hot highest-priority visible in-service level
//   highest_id[W]       index of highest_in_service, 0 when none
//   depth[W+1]          number of set isr bits
//   lowest_level[W]     current lowest-priority level L
//   ack_error           sticky acknowledge protocol error
module nested_in_service_ctrl #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ack_valid,
  input  logic [N-1:0] ack_vector,
  input  logic         aeoi,
  input  logic         smm,
  input  logic [N-1:0] mask,
  input  logic         cmd_valid,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_level,
  output logic [N-1:0] isr,
  output logic [N-1:0] highest_in_service,
  output logic [W-1:0] highest_id,
  output logic [W:0]   depth,
  output logic [W-1:0] lowest_level,
  output logic         ack_error
);

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_EOI_NS    = 3'b001,
    OP_EOI_SP    = 3'b010,
    OP_ROT_NS    = 3'b011,
    OP_ROT_SP    = 3'b100,
    OP_SET_PRI   = 3'b101,
    OP_SET_RAEOI = 3'b110,
    OP_CLR_RAEOI = 3'b111
  } cmd_op_e;

  cmd_op_e op;
  assign op = cmd_op_e'(cmd_op);

  // Highest-priority set bit of e given lowest level l, returned as
  // {found, index}. Levels are scanned from lowest priority (l) downward
  // with wrap, so the last hit is the highest-priority level (l+1).
  function automatic logic [W:0] find_top(input logic [N-1:0] e,
                                          input logic [W-1:0] l);
    logic         found;
    logic [W-1:0] idx;
    logic [W-1:0] lv;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lv = l - W'(i);
      if (e[lv]) begin
        found = 1'b1;
        idx   = lv;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [W:0] popcount(input logic [N-1:0] e);
    logic [W:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + {{W{1'b0}}, e[i]};
    end
    return cnt;
  endfunction

  function automatic logic [W-1:0] encode(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  logic [N-1:0] isr_q, isr_d;
  logic [W-1:0] l_q, l_d;
  logic         rot_aeoi_q, rot_aeoi_d;
  logic         ack_error_q, ack_error_d;
  logic [N-1:0] his_q, his_d;
  logic [W-1:0] hid_q, hid_d;
  logic [W:0]   depth_q, depth_d;

  logic [N-1:0] eff_cur, eff_next;
  logic [W:0]   top_cur, top_next;
  logic         ack_onehot;
  logic         ack_collide;
  logic [W-1:0] ack_idx;

  always_comb begin
    isr_d       = isr_q;
    l_d         = l_q;
    rot_aeoi_d  = rot_aeoi_q;
    ack_error_d = ack_error_q;
    his_d       = '0;
    hid_d       = '0;

    eff_cur = smm ? (isr_q & ~mask) : isr_q;
    top_cur = find_top(eff_cur, l_q);

    // Command acts on the current isr first.
    if (cmd_valid) begin
      case (op)
        OP_EOI_NS: begin
          if (top_cur[W]) isr_d[top_cur[W-1:0]] = 1'b0;
        end
        OP_EOI_SP: begin
          isr_d[cmd_level] = 1'b0;
        end
        OP_ROT_NS: begin
          if (top_cur[W]) begin
            isr_d[top_cur[W-1:0]] = 1'b0;
            l_d                   = top_cur[W-1:0];
          end
        end
        OP_ROT_SP: begin
          isr_d[cmd_level] = 1'b0;
          l_d              = cmd_level;
        end
        OP_SET_PRI:   l_d        = cmd_level;
        OP_SET_RAEOI: rot_aeoi_d = 1'b1;
        OP_CLR_RAEOI: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end

    // Acknowledge is checked against the post-command isr, so a same-cycle
    // specific EOI of the acknowledged level is a legal clear-then-set.
    ack_onehot  = (ack_vector != '0) && ((ack_vector & (ack_vector - N'(1))) == '0);
    ack_collide = (ack_vector & isr_d) != '0;
    ack_idx     = encode(ack_vector);

    if (ack_valid) begin
      if (!ack_onehot || ack_collide) begin
        ack_error_d = 1'b1;
      end else if (!aeoi) begin
        isr_d[ack_idx] = 1'b1;
      end else if (rot_aeoi_d) begin
        l_d = ack_idx;
      end
    end

    // Published status is derived from next-state isr/L so it lines up with
    // isr and lowest_level in the cycle after the edge.
    eff_next = smm ? (isr_d & ~mask) : isr_d;
    top_next = find_top(eff_next, l_d);
    if (top_next[W]) begin
      his_d[top_next[W-1:0]] = 1'b1;
      hid_d                  = top_next[W-1:0];
    end
    depth_d = popcount(isr_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      isr_q       <= '0;
      l_q         <= W'(N - 1);
      rot_aeoi_q  <= 1'b0;
      ack_error_q <= 1'b0;
      his_q       <= '0;
      hid_q       <= '0;
      depth_q     <= '0;
    end else begin
      isr_q       <= isr_d;
      l_q         <= l_d;
      rot_aeoi_q  <= rot_aeoi_d;
      ack_error_q <= ack_error_d;
      his_q       <= his_d;
      hid_q       <= hid_d;
      depth_q     <= depth_d;
    end
  end

  assign isr                = isr_q;
  assign highest_in_service = his_q;
  assign highest_id         = hid_q;
  assign depth              = depth_q;
  assign lowest_level       = l_q;
  assign ack_error          = ack_error_q;

endmodule
